// File: rtl/fifo_data_gen_pkg.sv
// Shared definitions for the AES datapath word FIFO.
//   DATA_W_DEF / DEPTH_DEF : default word width and number of entries
//   clog2()                : constant function sizing the pointers and the counter
package aes_fifo_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  // Ceiling log2; clog2(1) = 0. Intended for elaboration-time use only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_data_gen_if.sv
// Request/status bundle between a FIFO user (master) and fifo_data_gen (slave).
//   write_fifo, read_fifo, flush, clear_err, data_in : requests from the master
//   data_out, data_valid                             : read data and its strobe
//   counter_fifo                                     : occupancy
//   empty_fifo, full_fifo, almost_empty, almost_full : occupancy flags
//   overflow, underflow                              : sticky error flags
interface fifo_data_gen_if
  import aes_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CW     = clog2(DEPTH_DEF + 1)
);

  logic              write_fifo;
  logic              read_fifo;
  logic              flush;
  logic              clear_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [CW-1:0]     counter_fifo;
  logic              empty_fifo;
  logic              full_fifo;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output write_fifo, read_fifo, flush, clear_err, data_in,
    input  data_out, data_valid, counter_fifo, empty_fifo, full_fifo,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  write_fifo, read_fifo, flush, clear_err, data_in,
    output data_out, data_valid, counter_fifo, empty_fifo, full_fifo,
           almost_empty, almost_full, overflow, underflow
  );

endinterface

// File: rtl/fifo_data_gen_ptr_wrap.sv
// Modulo-DEPTH pointer: advances by one on inc, wraps DEPTH-1 -> 0.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous return to entry 0 (flush)
//   inc         : advance by one entry
//   ptr         : current entry index
module fifo_ptr_wrap
  import aes_fifo_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      // Explicit wrap: DEPTH need not be a power of two.
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_data_gen.sv
// Parametrised word FIFO between the bus interface and the AES-256 datapath.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : fifo_data_gen_if slave port carrying requests, registered read
//                 data with a one-cycle valid strobe, occupancy, flags, sticky errors
// A write into a full FIFO is accepted when a read is accepted in the same cycle.
// Flush wins over read/write, ignores their requests and leaves error flags alone.
module fifo_data_gen
  import aes_fifo_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int AFULL_TH  = 3,
  parameter  int AEMPTY_TH = 1,
  localparam int CW        = clog2(DEPTH + 1),
  localparam int PW        = clog2(DEPTH)
) (
  input logic            clk,
  input logic            resetn,
  fifo_data_gen_if.slave bus
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_data_gen: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_data_gen: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_data_gen: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     write_ptr;
  logic [PW-1:0]     read_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;
  logic rd_en;
  logic wr_en;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_acc = bus.read_fifo & ~empty;
  // A full FIFO still takes a write when the same cycle frees an entry.
  assign wr_acc = bus.write_fifo & (~full | rd_acc);
  assign rd_en  = rd_acc & ~bus.flush;
  assign wr_en  = wr_acc & ~bus.flush;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_write_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.flush),
    .inc    (wr_en),
    .ptr    (write_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_read_ptr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (bus.flush),
    .inc    (rd_en),
    .ptr    (read_ptr)
  );

  // NOTE: storage has no reset; only pointers and counter define which words are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[write_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (bus.flush)            count <= '0;
      else if (wr_en && !rd_en) count <= count + CW'(1);
      else if (rd_en && !wr_en) count <= count - CW'(1);

      data_valid_q <= rd_en;
      if (rd_en) data_out_q <= mem[read_ptr];

      // A set event in the same cycle beats clear_err; flush raises nothing.
      overflow_q  <= (bus.write_fifo & ~wr_acc & ~bus.flush) | (overflow_q  & ~bus.clear_err);
      underflow_q <= (bus.read_fifo  & ~rd_acc & ~bus.flush) | (underflow_q & ~bus.clear_err);
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.counter_fifo = count;
  assign bus.empty_fifo   = empty;
  assign bus.full_fifo    = full;
  assign bus.almost_empty = (count <= CW'(AEMPTY_TH));
  assign bus.almost_full  = (count >= CW'(AFULL_TH));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_data_gen.sv
// Directed bench for fifo_data_gen (DEPTH 4, AFULL_TH 3, AEMPTY_TH 1, DATA_W 32).
// Reads expected to be accepted push their hand-computed word into a queue; a
// monitor on the falling edge pops and compares whenever data_valid is high.
module tb_fifo_data_gen;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  logic [31:0] exp_q [$];

  fifo_data_gen_if #(.DATA_W(32), .CW(3)) bus ();

  fifo_data_gen #(
    .DATA_W    (32),
    .DEPTH     (4),
    .AFULL_TH  (3),
    .AEMPTY_TH (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of requests, applied away from the edge and dropped 1 unit after it.
  task automatic cycle(input logic w, input logic r, input logic f, input logic c,
                       input logic [31:0] d);
    bus.write_fifo = w;
    bus.read_fifo  = r;
    bus.flush      = f;
    bus.clear_err  = c;
    bus.data_in    = d;
    @(posedge clk);
    #1;
    bus.write_fifo = 1'b0;
    bus.read_fifo  = 1'b0;
    bus.flush      = 1'b0;
    bus.clear_err  = 1'b0;
    bus.data_in    = '0;
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic e, input logic f,
                             input logic ae, input logic af);
    check({tag, " count"},        32'(bus.counter_fifo), 32'(cnt));
    check({tag, " empty"},        32'(bus.empty_fifo),   32'(e));
    check({tag, " full"},         32'(bus.full_fifo),    32'(f));
    check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(ae));
    check({tag, " almost_full"},  32'(bus.almost_full),  32'(af));
  endtask

  task automatic check_err(input string tag, input logic ov, input logic un);
    check({tag, " overflow"},  32'(bus.overflow),  32'(ov));
    check({tag, " underflow"}, 32'(bus.underflow), 32'(un));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (resetn && bus.data_valid) begin
      logic [31:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data 0x%0h, expected no valid at %0t",
                 bus.data_out, $time);
      end else begin
        exp = exp_q.pop_front();
        if (bus.data_out !== exp) begin
          errors++;
          $display("FAIL read_data: got 0x%0h, expected 0x%0h at %0t", bus.data_out, exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fill_words [4];
    fill_words = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    checks = 0;
    errors = 0;
    resetn         = 1'b0;
    bus.write_fifo = 1'b0;
    bus.read_fifo  = 1'b0;
    bus.flush      = 1'b0;
    bus.clear_err  = 1'b0;
    bus.data_in    = '0;

    // Reset state.
    #2;
    check_flags("reset", 0, 1, 0, 1, 0);
    check_err("reset", 0, 0);
    check("reset data_valid", 32'(bus.data_valid), 32'd0);
    check("reset data_out",   bus.data_out,        32'd0);
    #1 resetn = 1'b1;

    // Fill 0xA0..0xA3.
    cycle(1, 0, 0, 0, fill_words[0]); check_flags("fill1", 1, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, fill_words[1]); check_flags("fill2", 2, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, fill_words[2]); check_flags("fill3", 3, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, fill_words[3]); check_flags("fill4", 4, 0, 1, 0, 1);

    // Drain in order; strobe is a single cycle.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(fill_words[i]);
      cycle(0, 1, 0, 0, '0);
      check("drain valid", 32'(bus.data_valid), 32'd1);
      check("drain count", 32'(bus.counter_fifo), 32'(3 - i));
    end
    @(posedge clk); #1;
    check("drain valid drops", 32'(bus.data_valid), 32'd0);
    check_flags("drained", 0, 1, 0, 1, 0);

    // Wrap-around: 2 words ahead, then 6 write+read pairs; pointers pass 3 -> 0.
    cycle(1, 0, 0, 0, 32'hC0);
    cycle(1, 0, 0, 0, 32'hC1);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(32'hC0 + 32'(i));
      cycle(1, 1, 0, 0, 32'hC2 + 32'(i));
      check("wrap count", 32'(bus.counter_fifo), 32'd2);
    end
    // Contents now C6, C7; fill to C6..C9.
    cycle(1, 0, 0, 0, 32'hC8);
    cycle(1, 0, 0, 0, 32'hC9);
    check_flags("refill", 4, 0, 1, 0, 1);

    // Full pass-through: oldest word out, 0xB5 in.
    exp_q.push_back(32'hC6);
    cycle(1, 1, 0, 0, 32'hB5);
    check_flags("passthru", 4, 0, 1, 0, 1);
    check_err("passthru", 0, 0);

    // Overflow, clear vs set, clear alone.
    cycle(1, 0, 0, 0, 32'hDD);
    check("ovf count", 32'(bus.counter_fifo), 32'd4);
    check_err("ovf", 1, 0);
    cycle(1, 0, 0, 1, 32'hDE);
    check_err("clear+set", 1, 0);
    cycle(0, 0, 0, 1, '0);
    check_err("clear", 0, 0);

    // Drain C7, C8, C9, B5 -- rejected writes must not have landed.
    exp_q.push_back(32'hC7);
    exp_q.push_back(32'hC8);
    exp_q.push_back(32'hC9);
    exp_q.push_back(32'hB5);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, '0);
    check_flags("drain2", 0, 1, 0, 1, 0);

    // Underflow, then write+read on empty: write taken, read rejected.
    cycle(0, 1, 0, 0, '0);
    check_err("unf", 0, 1);
    check("unf valid", 32'(bus.data_valid), 32'd0);
    cycle(0, 0, 0, 1, '0);
    check_err("unf clear", 0, 0);
    cycle(1, 1, 0, 0, 32'hE0);
    check("both empty count", 32'(bus.counter_fifo), 32'd1);
    check("both empty valid", 32'(bus.data_valid), 32'd0);
    check_err("both empty", 0, 1);
    cycle(0, 0, 0, 1, '0);

    // Flush at count 3 with both requests.
    cycle(1, 0, 0, 0, 32'hE1);
    cycle(1, 0, 0, 0, 32'hE2);
    check("preflush count", 32'(bus.counter_fifo), 32'd3);
    cycle(1, 1, 1, 0, 32'hF0);
    check_flags("flush", 0, 1, 0, 1, 0);
    check("flush valid", 32'(bus.data_valid), 32'd0);
    check("flush data_out", bus.data_out, 32'hB5);
    check_err("flush", 0, 0);
    cycle(0, 1, 0, 0, '0);
    check_err("post flush read", 0, 1);
    cycle(0, 0, 1, 0, '0);
    check_err("flush keeps err", 0, 1);
    cycle(0, 0, 0, 1, '0);

    // Async reset with data_valid high at count 2.
    cycle(1, 0, 0, 0, 32'h11);
    cycle(1, 0, 0, 0, 32'h22);
    cycle(1, 0, 0, 0, 32'h33);
    exp_q.push_back(32'h11);
    cycle(0, 1, 0, 0, '0);
    check("pre reset count", 32'(bus.counter_fifo), 32'd2);
    #5;
    check("pre reset valid", 32'(bus.data_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check_flags("async reset", 0, 1, 0, 1, 0);
    check("async reset valid", 32'(bus.data_valid), 32'd0);
    check("async reset data",  bus.data_out,        32'd0);
    #1 resetn = 1'b1;

    // First writes after release land at entry 0 and read back from entry 0.
    cycle(1, 0, 0, 0, 32'h44);
    cycle(1, 0, 0, 0, 32'h55);
    exp_q.push_back(32'h44);
    cycle(0, 1, 0, 0, '0);
    exp_q.push_back(32'h55);
    cycle(0, 1, 0, 0, '0);
    check_flags("post reset", 0, 1, 0, 1, 0);

    @(posedge clk); #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
